demux_sched_1to4: RTL and testbench

DEMUX_SCHED_1TO4 -- requirements
Module: demux_sched_1to4

---
 rtl/demux_sched_pkg.sv | 17 +
 rtl/demux_sched_1to4_if.sv | 28 ++
 rtl/rr_arbiter4.sv | 32 +++
 rtl/demux_sched_1to4.sv | 99 +++++++++
 tb/tb_demux_sched_1to4.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_sched_pkg.sv
// Shared definitions for the 1-to-4 burst demultiplexer.
//   CH_NUM   : number of downstream channels
//   ch_idx_t : channel index type
//   state_t  : scheduler FSM states
package demux_sched_pkg;

  localparam int unsigned CH_NUM = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/demux_sched_1to4_if.sv
// Stream bus of the 1-to-4 demultiplexer.
//   in_valid/in_data/in_ready    : upstream beat handshake
//   out_valid/out_data/out_ready : per-channel valid/ready, shared payload
// master = upstream/downstream environment, slave = the demultiplexer.
interface demux_sched_1to4_if
  import demux_sched_pkg::*;
#(
  parameter int unsigned DW = 8
);

  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic [CH_NUM-1:0] out_valid;
  logic [DW-1:0]     out_data;
  logic [CH_NUM-1:0] out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick over 4 requesters.
//   req       : request mask
//   last      : most recently served index (lowest priority)
//   gnt_valid : some request is set
//   gnt_idx   : first set request scanning from last+1 (mod 4)
module rr_arbiter4
  import demux_sched_pkg::*;
(
  input  logic [CH_NUM-1:0] req,
  input  ch_idx_t           last,
  output logic              gnt_valid,
  output ch_idx_t           gnt_idx
);

  ch_idx_t idx;

  // Scan from lowest priority (last+4 == last) up to highest (last+1),
  // so the highest-priority hit is the one left standing.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last;
    idx       = last;
    for (int unsigned k = CH_NUM; k > 0; k--) begin
      idx = last + ch_idx_t'(k);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/demux_sched_1to4.sv
// 1-to-4 stream demultiplexer with round-robin burst scheduling.
// A granted channel receives up to BURST beats through a single-entry
// output register, then the scheduler drains and re-arbitrates.
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg_en     : per-channel enable mask
//   sel        : currently granted channel
//   busy       : scheduler in XFER or DRAIN
//   bus        : stream interface (slave side)
module demux_sched_1to4
  import demux_sched_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CH_NUM-1:0]  cfg_en,
  output ch_idx_t            sel,
  output logic               busy,
  demux_sched_1to4_if.slave  bus
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  state_t        state_q, state_d;
  ch_idx_t       sel_q, last_q;
  logic [3:0]    count_q;
  logic          buf_valid_q;
  logic [DW-1:0] data_q;

  logic    gnt_valid;
  ch_idx_t gnt_idx;
  logic    sel_en, accept, handshake, last_beat;

  rr_arbiter4 u_arb (
    .req       (cfg_en),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel_en    = cfg_en[sel_q];
  assign handshake = buf_valid_q && bus.out_ready[sel_q];
  assign accept    = bus.in_valid && bus.in_ready;
  // Leave XFER on the edge of the final accept so the gap is DRAIN+IDLE only.
  assign last_beat = accept && ((count_q + 4'd1) == BURST_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_valid)                  state_d = XFER;
      XFER:    if (last_beat || !sel_en)       state_d = DRAIN;
      DRAIN:   if (!buf_valid_q || handshake)  state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == XFER) && sel_en && (count_q < BURST_C) &&
                    (!buf_valid_q || bus.out_ready[sel_q]);
    bus.out_valid = buf_valid_q ? (4'(1) << sel_q) : '0;
    busy          = (state_q != IDLE);
  end

  // sel only moves in IDLE, where the buffer is always empty, so a buffered
  // beat is never redirected to another channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      last_q      <= 2'd3;
      count_q     <= '0;
      buf_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      if (state_q == IDLE && gnt_valid) begin
        sel_q   <= gnt_idx;
        count_q <= '0;
      end else if (accept) begin
        count_q <= count_q + 4'd1;
      end
      if (state_q == DRAIN && state_d == IDLE) last_q <= sel_q;
      if (accept) begin
        buf_valid_q <= 1'b1;
        data_q      <= bus.in_data;
      end else if (handshake) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

  assign sel          = sel_q;
  assign bus.out_data = data_q;

endmodule

// File: tb/tb_demux_sched_1to4.sv
module tb_demux_sched_1to4;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cfg_en = 4'b0000;
  logic [1:0] sel;
  logic       busy;

  demux_sched_1to4_if #(.DW(DW)) bus ();

  demux_sched_1to4 #(.DW(DW), .BURST(BURST)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg_en (cfg_en),
    .sel    (sel),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int ch; logic [7:0] data; int cyc; } beat_t;
  beat_t acc_log[$];
  beat_t dlv_log[$];

  int         m_phase;     // 0 waiting for grant, 1 streaming, 2 flushing
  int         m_ch, m_last, m_cnt;
  logic [7:0] m_od;
  logic [7:0] m_buf[$];
  int         cyc = 0;

  always @(negedge clk) begin
    logic       exp_ir, acc, hs, found;
    logic [3:0] exp_ov;
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_ch = 0; m_last = 3; m_cnt = 0; m_od = '0;
      m_buf.delete();
    end else begin
      exp_ir = (m_phase == 1) && cfg_en[m_ch] && (m_cnt < BURST) &&
               (m_buf.size() == 0 || bus.out_ready[m_ch]);
      exp_ov = (m_buf.size() != 0) ? 4'(1 << m_ch) : 4'd0;
      check("in_ready",  32'(bus.in_ready),  32'(exp_ir));
      check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      check("out_data",  32'(bus.out_data),  32'(m_od));
      check("busy",      32'(busy),          32'(m_phase != 0));
      check("sel",       32'(sel),           32'(m_ch));
      hs  = (m_buf.size() != 0) && bus.out_ready[m_ch];
      acc = bus.in_valid && exp_ir;
      if (hs) dlv_log.push_back('{m_ch, m_buf.pop_front(), cyc});
      if (acc) begin
        m_buf.push_back(bus.in_data);
        m_od = bus.in_data;
        m_cnt++;
        acc_log.push_back('{m_ch, bus.in_data, cyc});
      end
      case (m_phase)
        0: begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++)
            if (!found && cfg_en[(m_last + k) % 4]) begin
              found = 1'b1; m_ch = (m_last + k) % 4; m_cnt = 0; m_phase = 1;
            end
        end
        1: if ((acc && m_cnt == BURST) || !cfg_en[m_ch]) m_phase = 2;
        2: if (m_buf.size() == 0) begin m_last = m_ch; m_phase = 0; end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  // mode 0: hold data, 1: increment data after each accept, 2: random data
  task automatic step(int mode);
    logic a;
    @(negedge clk);
    a = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    if (mode == 1 && a) bus.in_data = bus.in_data + 8'd1;
    if (mode == 2)      bus.in_data = 8'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_busy",      32'(busy),          32'h0);
    check("rst_sel",       32'(sel),           32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    acc_log.delete();
    dlv_log.delete();
  endtask

  task automatic wait_acc(int n, int mode, string name);
    int guard = 0;
    while (acc_log.size() < n && guard < 60) begin step(mode); guard++; end
    check(name, 32'(acc_log.size() >= n), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    int c0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 4'b1111;
    repeat (2) @(posedge clk);

    // all channels, continuous traffic
    cfg_en = 4'b1111; bus.in_valid = 1'b1;
    do_reset();
    repeat (40) step(2);
    check("s1_count", 32'(dlv_log.size() >= 20), 32'h1);
    for (int i = 0; i < 20 && i < dlv_log.size(); i++) begin
      check("s1_channel", 32'(dlv_log[i].ch), 32'((i / 4) % 4));
      check("s1_accept_time", 32'(acc_log[i].cyc - acc_log[0].cyc), 32'((i / 4) * 6 + i % 4));
      check("s1_latency", 32'(dlv_log[i].cyc - acc_log[i].cyc), 32'd1);
    end

    // single channel 2, data A0..A7
    cfg_en = 4'b0100; bus.in_valid = 1'b1; bus.in_data = 8'hA0;
    do_reset();
    wait_acc(8, 1, "s2_accepts");
    bus.in_valid = 1'b0;
    repeat (6) step(0);
    check("s2_count", 32'(dlv_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < dlv_log.size(); i++) begin
      check("s2_channel", 32'(dlv_log[i].ch), 32'd2);
      check("s2_data", 32'(dlv_log[i].data), 32'(8'hA0 + i));
      check("s2_latency", 32'(dlv_log[i].cyc - acc_log[i].cyc), 32'd1);
    end
    if (acc_log.size() >= 5)
      check("s2_burst_gap", 32'(acc_log[4].cyc - acc_log[3].cyc), 32'd3);

    // channel 1 with a 3-cycle downstream stall
    cfg_en = 4'b0010; bus.in_valid = 1'b1; bus.in_data = 8'h10;
    do_reset();
    wait_acc(2, 1, "s3_two_accepts");
    bus.out_ready = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3_stall_in_ready", 32'(bus.in_ready), 32'h0);
      check("s3_stall_out_valid", 32'(bus.out_valid), 32'b0010);
      check("s3_stall_data", 32'(bus.out_data), 32'h11);
      @(posedge clk); #1;
    end
    bus.out_ready = 4'b1111;
    wait_acc(8, 1, "s3_accepts");
    bus.in_valid = 1'b0;
    repeat (6) step(0);
    check("s3_count", 32'(dlv_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < dlv_log.size(); i++) begin
      check("s3_channel", 32'(dlv_log[i].ch), 32'd1);
      check("s3_data", 32'(dlv_log[i].data), 32'(8'h10 + i));
    end

    // disable granted channel mid-burst
    cfg_en = 4'b1111; bus.in_valid = 1'b1;
    do_reset();
    wait_acc(2, 2, "s4_two_accepts");
    cfg_en = 4'b1110;
    @(negedge clk);
    check("s4_in_ready_drop", 32'(bus.in_ready), 32'h0);
    check("s4_buffered", 32'(bus.out_valid), 32'b0001);
    @(posedge clk); #1;
    repeat (10) step(2);
    c0 = 0;
    foreach (acc_log[i]) if (acc_log[i].ch == 0) c0++;
    check("s4_ch0_beats", 32'(c0), 32'd2);
    if (dlv_log.size() >= 2) check("s4_buffered_dlv_ch", 32'(dlv_log[1].ch), 32'd0);
    check("s4_next_grant", 32'(acc_log.size() > 2 ? acc_log[2].ch : -1), 32'd1);

    // reset with a buffered beat
    cfg_en = 4'b1111; bus.in_valid = 1'b1;
    do_reset();
    wait_acc(1, 2, "s5_one_accept");
    bus.out_ready = 4'b0000;
    step(0);
    check("s5_buffered", 32'(bus.out_valid), 32'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("s5_rst_in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1; bus.out_ready = 4'b1111;
    acc_log.delete(); dlv_log.delete();
    @(negedge clk);
    check("s5_post_in_ready", 32'(bus.in_ready), 32'h0);
    check("s5_post_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    wait_acc(1, 2, "s5_regrant");
    check("s5_first_grant", 32'(acc_log.size() > 0 ? acc_log[0].ch : -1), 32'd0);

    // no channel enabled
    cfg_en = 4'b0000; bus.in_valid = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("s6_in_ready", 32'(bus.in_ready), 32'h0);
      check("s6_busy", 32'(busy), 32'h0);
      check("s6_out_valid", 32'(bus.out_valid), 32'h0);
      @(posedge clk); #1;
    end

    // randomized traffic
    cfg_en = 4'b1111;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) cfg_en = 4'($urandom);
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = 4'($urandom) | 4'($urandom);
      step(2);
    end
    bus.in_valid = 1'b0; bus.out_ready = 4'b1111;
    repeat (10) step(0);
    check("rand_drained", 32'(bus.out_valid), 32'h0);
    held = bus.out_data;
    check("rand_hold_data", 32'(held), 32'(m_od));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
